// File: rtl/led_afterglow_pwm.sv
// LED output stage: per-LED brightness rendered by a free-running PWM, with a
// one-level-per-tick afterglow fade for LEDs whose pattern bit drops to 0.
module led_afterglow_pwm #(
    parameter int width    = 8,
    parameter int pwm_bits = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic [width-1:0]    pattern,
    input  logic [pwm_bits-1:0] duty,
    output logic [width-1:0]    leds,
    output logic                frame
);

    localparam int                  PERIOD   = (1 << pwm_bits) - 1;
    localparam logic [pwm_bits-1:0] CNT_LAST = pwm_bits'(PERIOD - 1);

    logic [pwm_bits-1:0] pwm_cnt_reg;
    logic                pending_reg;
    logic                frame_reg;
    logic [width-1:0]    leds_reg;
    logic [pwm_bits-1:0] bright_reg  [width];
    logic [pwm_bits-1:0] bright_next [width];
    logic [width-1:0]    leds_next;
    logic                boundary;
    logic                fade;

    assign boundary = (pwm_cnt_reg == CNT_LAST);
    // A step landing in the boundary cycle itself still counts for this boundary.
    assign fade     = pending_reg | step;

    generate
        for (genvar gi = 0; gi < width; gi++) begin : g_led
            always_comb begin
                bright_next[gi] = bright_reg[gi];
                if (boundary) begin
                    if (pattern[gi]) begin
                        bright_next[gi] = duty;
                    end else if (fade && (bright_reg[gi] != '0)) begin
                        bright_next[gi] = bright_reg[gi] - 1'b1;
                    end
                end
            end
            assign leds_next[gi] = (pwm_cnt_reg < bright_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_reg <= '0;
            pending_reg <= 1'b0;
            frame_reg   <= 1'b0;
            leds_reg    <= '0;
            for (int k = 0; k < width; k++) begin
                bright_reg[k] <= '0;
            end
        end else begin
            pwm_cnt_reg <= boundary ? '0 : pwm_cnt_reg + 1'b1;
            pending_reg <= boundary ? 1'b0 : (pending_reg | step);
            frame_reg   <= boundary;
            leds_reg    <= leds_next;
            for (int k = 0; k < width; k++) begin
                bright_reg[k] <= bright_next[k];
            end
        end
    end

    assign leds  = leds_reg;
    assign frame = frame_reg;

endmodule

// File: tb/tb_led_afterglow_pwm.sv
// Scoreboard bench: stimulus computes per-period LED levels and queues them;
// a negedge monitor collects each 15-cycle PWM window and checks it.
module tb_led_afterglow_pwm;

    localparam int W  = 8;
    localparam int PB = 4;
    localparam int P  = 15;

    typedef logic [W-1:0][PB-1:0] lvls_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          step = 1'b0;
    logic [W-1:0]  pattern = '0;
    logic [PB-1:0] duty = '0;
    logic [W-1:0]  leds;
    logic          frame;

    led_afterglow_pwm #(.width(W), .pwm_bits(PB)) dut (
        .clk(clk), .rst(rst), .step(step), .pattern(pattern),
        .duty(duty), .leds(leds), .frame(frame)
    );

    always #5 clk = ~clk;

    int       n_tests = 0;
    int       n_fail  = 0;
    lvls_t    exp_q[$];
    int       lvl[W];
    logic     rst_q = 1'b0;
    bit       mon_en = 1'b0;
    int       widx = 0;
    int       nwin = 0;
    logic [W-1:0] win[P];
    logic     frm[P];

    always @(posedge clk) rst_q <= rst;

    // Monitor: one window = the 15 samples after a frame pulse, ending on the next one.
    always @(negedge clk) begin : monitor
        lvls_t e;
        bit    ok_f;
        bit    ok_l;
        int    bad_j;
        int    bad_k;
        if (mon_en) begin
            if (rst_q) begin
                n_tests++;
                if (leds !== '0 || frame !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL reset_outputs: leds=%h frame=%b, required leds=00 frame=0", leds, frame);
                end
                widx = 0;
            end else begin
                win[widx] = leds;
                frm[widx] = frame;
                if (widx == P - 1) begin
                    widx = 0;
                    nwin++;
                    ok_f = (frm[P-1] === 1'b1);
                    for (int j = 0; j < P - 1; j++) if (frm[j] !== 1'b0) ok_f = 0;
                    n_tests++;
                    if (!ok_f) begin
                        n_fail++;
                        $display("[TB] FAIL frame_position window %0d: frame not exactly at window end (last=%b), required 15-cycle period", nwin, frm[P-1]);
                    end
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL scoreboard_underflow window %0d: no expected levels queued", nwin);
                    end else begin
                        e = exp_q.pop_front();
                        ok_l = 1;
                        bad_j = 0;
                        bad_k = 0;
                        for (int j = 0; j < P; j++) begin
                            for (int k = 0; k < W; k++) begin
                                if (ok_l && (win[j][k] !== (j < int'(e[k])))) begin
                                    ok_l = 0;
                                    bad_j = j;
                                    bad_k = k;
                                end
                            end
                        end
                        if (!ok_l) begin
                            n_fail++;
                            $display("[TB] FAIL led_window %0d: cycle %0d led %0d got %b, required %b (level %0d)",
                                     nwin, bad_j, bad_k, win[bad_j][bad_k], (bad_j < int'(e[bad_k])), e[bad_k]);
                        end else begin
                            $display("[TB] window %0d ok levels=%h", nwin, e);
                        end
                    end
                end else begin
                    widx++;
                end
            end
        end
    end

    // One PWM period: inputs switch from 'before' to 'after' at cycle chg_t;
    // the boundary (cycle 14) always sees the 'after' values.
    task automatic run_period(input logic [W-1:0] pb, input logic [PB-1:0] db,
                              input logic [W-1:0] pa, input logic [PB-1:0] da,
                              input int chg_t, input logic [P-1:0] mask);
        lvls_t nl;
        bit    fade;
        for (int t = 0; t < P; t++) begin
            if (t < chg_t) begin
                pattern = pb;
                duty    = db;
            end else begin
                pattern = pa;
                duty    = da;
            end
            step = mask[t];
            @(posedge clk);
            #1;
        end
        step = 1'b0;
        fade = (mask != '0);
        for (int k = 0; k < W; k++) begin
            if (pa[k]) lvl[k] = int'(da);
            else if (fade && lvl[k] > 0) lvl[k] = lvl[k] - 1;
            nl[k] = PB'(lvl[k]);
        end
        exp_q.push_back(nl);
    endtask

    task automatic do_reset(input int n, input logic [W-1:0] p, input logic [PB-1:0] d);
        rst     = 1'b1;
        step    = 1'b1;
        pattern = p;
        duty    = d;
        // The newest entry belongs to a window that the reset wipes out.
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        for (int k = 0; k < W; k++) lvl[k] = 0;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (n - 1) @(posedge clk);
        #1;
        rst  = 1'b0;
        step = 1'b0;
        exp_q.push_back('0);
    endtask

    initial begin
        do_reset(3, 8'hFF, 4'd15);
        run_period(8'hFF, 4'd15, 8'hFF, 4'd15, 0, '0);
        run_period(8'hFF, 4'd15, 8'hFF, 4'd15, 0, '0);

        for (int i = 0; i < 3; i++) run_period(8'h81, 4'd5, 8'h81, 4'd5, 0, '0);

        for (int i = 0; i < 2; i++) run_period(8'h01, 4'd15, 8'h01, 4'd15, 0, '0);
        for (int i = 0; i < 16; i++)
            run_period(8'h00, 4'd15, 8'h00, 4'd15, 0, 15'(1) << $urandom_range(14, 0));

        run_period(8'h01, 4'd15, 8'h01, 4'd15, 0, '0);
        run_period(8'h00, 4'd15, 8'h00, 4'd15, 0, 15'b000_0100_1000_0010);
        run_period(8'h00, 4'd15, 8'h00, 4'd15, 0, 15'h4000);
        run_period(8'h00, 4'd15, 8'h00, 4'd15, 0, '0);

        run_period(8'h01, 4'd15, 8'h01, 4'd15, 0, '0);
        run_period(8'h01, 4'd15, 8'h02, 4'd3, 7, '0);
        run_period(8'h02, 4'd3, 8'h02, 4'd3, 0, '0);
        run_period(8'h02, 4'd3, 8'h02, 4'd3, 0, '0);

        run_period(8'h01, 4'd9, 8'h01, 4'd9, 0, '0);
        run_period(8'h00, 4'd9, 8'h00, 4'd9, 0, '0);
        do_reset(1, 8'h00, 4'd0);
        for (int i = 0; i < 3; i++)
            run_period(8'h00, 4'd9, 8'h00, 4'd9, 0, 15'(1) << $urandom_range(14, 0));

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0]  pb;
            logic [W-1:0]  pa;
            logic [PB-1:0] db;
            logic [PB-1:0] da;
            logic [P-1:0]  mask;
            pb   = W'($urandom);
            db   = PB'($urandom);
            pa   = W'($urandom & $urandom);
            da   = PB'($urandom);
            mask = ($urandom_range(0, 3) == 0) ? '0 : P'($urandom & $urandom & $urandom);
            run_period(pb, db, pa, da, $urandom_range(14, 0), mask);
        end

        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d windows never completed, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
